// File: rtl/phy_tx_pkg.sv
// Shared constants, types and index helpers for the multi-lane PHY transmitter.
package phy_tx_pkg;

   localparam logic [7:0] COM_SYM = 8'hBC;

   typedef enum logic [1:0] {
      SRC_IDLE,
      SRC_HOLD,
      SRC_BYPASS
   } word_src_t;

   // Byte j of a word rides on lane j mod LANES in slot j div LANES.
   function automatic int byte_index(input int slot, input int lane, input int lanes);
      return slot * lanes + lane;
   endfunction

   function automatic int lane_of(input int byte_idx, input int lanes);
      return byte_idx % lanes;
   endfunction

   function automatic int slot_of(input int byte_idx, input int lanes);
      return byte_idx / lanes;
   endfunction

   function automatic bit params_ok(input int data_w, input int lanes);
      return (data_w > 0) && (data_w % 8 == 0) && (lanes > 0) && ((data_w / 8) % lanes == 0);
   endfunction

   function automatic int slot_width(input int k);
      return (k <= 1) ? 1 : $clog2(k);
   endfunction

endpackage

// File: rtl/phy_tx_hold.sv
// One-entry hold buffer in front of the transmitter; it drains only at a word boundary.
module phy_tx_hold
   import phy_tx_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] word,
   input  logic              valid,
   input  logic              wb,
   output logic              ready,
   output logic              accept,
   output logic [DATA_W-1:0] held_word,
   output logic              held
);

   // Ready is held low during reset so nothing is accepted while the lanes are dark.
   assign ready  = !held && rst_n;
   assign accept = valid && ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held      <= 1'b0;
         held_word <= '0;
      end else if (wb) begin
         held <= 1'b0;
      end else if (accept) begin
         held      <= 1'b1;
         held_word <= word;
      end
   end

endmodule

// File: rtl/phy_tx_multilane.sv
// Byte-striping multi-lane serial transmitter running on the bit clock, with COM idle fill.
module phy_tx_multilane
   import phy_tx_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          LANES     = 2,
   parameter logic [7:0]  IDLE_BYTE = COM_SYM
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [LANES-1:0]  data_out,
   output logic              tx_active
);

   localparam int                B         = DATA_W / 8;
   localparam int                K         = B / LANES;
   localparam int                SW        = slot_width(K);
   localparam logic [SW-1:0]     SLOT_LAST = SW'(K - 1);
   localparam logic [DATA_W-1:0] IDLE_WORD = {B{IDLE_BYTE}};

   generate
      if (!params_ok(DATA_W, LANES)) begin : g_bad_params
         $error("phy_tx_multilane: DATA_W must be a multiple of 8 and LANES must divide DATA_W/8");
      end
   endgenerate

   logic [2:0]        bit_cnt;
   logic [SW-1:0]     slot_cnt;
   logic              wb;
   logic [DATA_W-1:0] cur_word;
   logic              cur_is_data;
   logic [DATA_W-1:0] hold_word;
   logic              hold_valid;
   logic              accept;
   word_src_t         src;
   logic [LANES-1:0]  lane_bits;
   logic [7:0]        lane_byte;

   assign wb = (bit_cnt == 3'd7) && (slot_cnt == SLOT_LAST);

   phy_tx_hold #(
      .DATA_W(DATA_W)
   ) u_hold (
      .clk       (clk_32f),
      .rst_n     (reset),
      .word      (data_in),
      .valid     (valid_in),
      .wb        (wb),
      .ready     (ready_out),
      .accept    (accept),
      .held_word (hold_word),
      .held      (hold_valid)
   );

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         bit_cnt  <= 3'd0;
         slot_cnt <= '0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) begin
            slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SW'(1);
         end
      end
   end

   // A held word always wins at the boundary so acceptance order is preserved.
   always_comb begin
      src = SRC_IDLE;
      if (hold_valid) begin
         src = SRC_HOLD;
      end else if (accept) begin
         src = SRC_BYPASS;
      end
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         cur_word    <= IDLE_WORD;
         cur_is_data <= 1'b0;
      end else if (wb) begin
         unique case (src)
            SRC_HOLD: begin
               cur_word    <= hold_word;
               cur_is_data <= 1'b1;
            end
            SRC_BYPASS: begin
               cur_word    <= data_in;
               cur_is_data <= 1'b1;
            end
            default: begin
               cur_word    <= IDLE_WORD;
               cur_is_data <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      lane_bits = '0;
      lane_byte = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_byte    = 8'(cur_word >> (8 * byte_index(int'(slot_cnt), l, LANES)));
         lane_bits[l] = lane_byte[3'd7 - bit_cnt];
      end
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         tx_active <= 1'b0;
      end else begin
         data_out  <= lane_bits;
         tx_active <= cur_is_data;
      end
   end

endmodule

// File: tb/tb_phy_tx_multilane.sv
// Scoreboard bench for phy_tx_multilane: a 2-lane instance and a 4-lane (K=1) instance.
module tb_phy_tx_multilane;

   localparam logic [7:0] IDLE = 8'hBC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_in, data_in4;
   logic        valid_in, valid_in4;
   logic        ready_out, ready_out4;
   logic        tx_active, tx_active4;
   logic [1:0]  data_out;
   logic [3:0]  data_out4;

   int n_checks   = 0;
   int n_fail     = 0;
   int edges_done = 0;
   int words_seen = 0;
   int nbits      = 0;
   logic [15:0] sh0, sh1;
   logic [31:0] sb[$];
   logic [31:0] sb4[$];

   always #5 clk = ~clk;

   phy_tx_multilane #(.DATA_W(32), .LANES(2), .IDLE_BYTE(IDLE)) dut (
      .clk_32f  (clk),
      .reset    (rst_n),
      .data_in  (data_in),
      .valid_in (valid_in),
      .ready_out(ready_out),
      .data_out (data_out),
      .tx_active(tx_active)
   );

   phy_tx_multilane #(.DATA_W(32), .LANES(4), .IDLE_BYTE(IDLE)) dut4 (
      .clk_32f  (clk),
      .reset    (rst_n),
      .data_in  (data_in4),
      .valid_in (valid_in4),
      .ready_out(ready_out4),
      .data_out (data_out4),
      .tx_active(tx_active4)
   );

   // Edge e after reset release is the (e+1)-th rising edge with reset high.
   always @(posedge clk) begin
      if (!rst_n) edges_done = 0;
      else        edges_done++;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic go_to_edge(input int e);
      while (edges_done < e) @(negedge clk);
   endtask

   // Presents one word for a single edge on the 2-lane instance.
   task automatic apply_stimulus(input logic [31:0] w, input bit expect_accept);
      check_output("ready_before_drive", 32'(ready_out), 32'(expect_accept));
      valid_in = 1'b1;
      data_in  = w;
      if (expect_accept) sb.push_back(w);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   // Monitor: idle bits must follow the COM pattern, data bits are rebuilt into words.
   always @(negedge clk) begin
      int          e;
      logic [7:0]  idle_v;
      logic        ib;
      logic [31:0] got;
      idle_v = IDLE;
      if (!rst_n) begin
         nbits = 0;
      end else if (edges_done > 0) begin
         e = edges_done - 1;
         if (tx_active !== 1'b1) begin
            ib = idle_v[3'(7 - (e % 8))];
            check_output("idle_bits", 32'(data_out), 32'({ib, ib}));
            if (nbits != 0) begin
               check_output("word_truncated", 32'(nbits), 32'd0);
               nbits = 0;
            end
         end else begin
            if (nbits == 0) check_output("word_align", 32'(e % 16), 32'd0);
            sh0 = {sh0[14:0], data_out[0]};
            sh1 = {sh1[14:0], data_out[1]};
            nbits++;
            if (nbits == 16) begin
               nbits = 0;
               words_seen++;
               got = {sh1[7:0], sh0[7:0], sh1[15:8], sh0[15:8]};
               check_output("sb_pending", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) check_output("word_data", got, sb.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        hv, acc;
      int          last;
      int          n_acc;
      logic [7:0]  b4[4];
      logic [31:0] exp4;

      rst_n = 1'b0; valid_in = 1'b0; data_in = '0; valid_in4 = 1'b0; data_in4 = '0;
      repeat (3) @(negedge clk);
      check_output("rst_data_out",   32'(data_out),   32'd0);
      check_output("rst_tx_active",  32'(tx_active),  32'd0);
      check_output("rst_ready",      32'(ready_out),  32'd0);
      check_output("rst_data_out4",  32'(data_out4),  32'd0);
      check_output("rst_ready4",     32'(ready_out4), 32'd0);
      rst_n = 1'b1;
      $display("[TB] reset released, idle then single word at first boundary");

      go_to_edge(15);
      check_output("idle_tx_active", 32'(tx_active), 32'd0);
      apply_stimulus(32'hA1B2C3D4, 1'b1);
      check_output("edge15_tx_active", 32'(tx_active), 32'd0);
      while (edges_done < 32) begin
         @(negedge clk);
         check_output("single_active", 32'(tx_active), 32'd1);
      end
      @(negedge clk);
      check_output("single_done", 32'(tx_active), 32'd0);

      $display("[TB] mid-period word goes through the hold register");
      go_to_edge(52);
      apply_stimulus(32'h55667788, 1'b1);
      go_to_edge(54);
      apply_stimulus(32'hDEAD0054, 1'b0);
      while (edges_done < 64) begin
         check_output("hold_ready_low", 32'(ready_out), 32'd0);
         @(negedge clk);
      end
      check_output("hold_ready_back", 32'(ready_out), 32'd1);
      check_output("hold_not_yet_active", 32'(tx_active), 32'd0);
      @(negedge clk);
      check_output("hold_word_active", 32'(tx_active), 32'd1);

      $display("[TB] back-to-back words with valid held high");
      go_to_edge(80);
      hv = 1'b0; n_acc = 0;
      valid_in = 1'b1; data_in = 32'h10000001;
      while (edges_done < 180) begin
         check_output("b2b_ready", 32'(ready_out), 32'(!hv));
         acc = valid_in && !hv;
         if (acc) sb.push_back(data_in);
         hv = ((edges_done % 16) == 15) ? 1'b0 : (hv | acc);
         @(negedge clk);
         if (acc) begin
            n_acc++;
            data_in = data_in + 32'd1;
            if (n_acc == 5) valid_in = 1'b0;
         end
         last = edges_done - 1;
         if (last >= 96 && last <= 175) check_output("b2b_no_gap", 32'(tx_active), 32'd1);
      end

      $display("[TB] reset in the middle of a word with the hold register full");
      go_to_edge(192);
      apply_stimulus(32'hCAFE0001, 1'b1);
      go_to_edge(208);
      apply_stimulus(32'hCAFE0002, 1'b1);
      go_to_edge(217);
      check_output("pre_reset_ready", 32'(ready_out), 32'd0);
      check_output("pre_reset_active", 32'(tx_active), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("abort_data_out",  32'(data_out),  32'd0);
      check_output("abort_tx_active", 32'(tx_active), 32'd0);
      check_output("abort_ready",     32'(ready_out), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      while (edges_done < 40) begin
         @(negedge clk);
         check_output("post_reset_idle", 32'(tx_active), 32'd0);
      end

      $display("[TB] four lanes, one byte per lane per word");
      go_to_edge(47);
      check_output("lane4_ready", 32'(ready_out4), 32'd1);
      valid_in4 = 1'b1;
      data_in4  = 32'h11223344;
      sb4.push_back(data_in4);
      @(negedge clk);
      valid_in4 = 1'b0;
      check_output("lane4_pre_active", 32'(tx_active4), 32'd0);
      for (int l = 0; l < 4; l++) b4[l] = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_output("lane4_active", 32'(tx_active4), 32'd1);
         for (int l = 0; l < 4; l++) b4[l] = {b4[l][6:0], data_out4[l]};
      end
      exp4 = sb4.pop_front();
      for (int l = 0; l < 4; l++) check_output("lane4_byte", 32'(b4[l]), 32'(exp4[8*l +: 8]));
      @(negedge clk);
      check_output("lane4_done", 32'(tx_active4), 32'd0);

      repeat (20) @(negedge clk);
      check_output("sb_drained", 32'(sb.size()), 32'd0);
      check_output("words_seen", 32'(words_seen), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phy_tx_multilane.md
# phy_tx_multilane

Parametrised multi-lane PCIe-style PHY transmitter. Accepts DATA_W-bit words through a valid/ready handshake and byte-stripes each word across LANES serial lanes. Serialises bytes MSB-first at one bit per clock and inserts COM idle symbols whenever no data word is pending. It is the generalised successor to the fixed two-lane PHY_TX. It runs on the bit clock alone, using internal counters in place of divided clocks.

## Interface
- DATA_W, 32, input word width; multiple of 8
- LANES, 2, serial lane count; must divide DATA_W/8 (elaboration error otherwise)
- IDLE_BYTE, 8'hBC, symbol sent on every lane when idle
- clk_32f  input  1  bit clock; single clock domain, rising edge
- reset  input  1  asynchronous, active-low reset
- data_in  input  DATA_W  word to send; byte j = data_in[8j+7:8j]
- valid_in  input  1  data_in valid
- ready_out  output  1  block can accept a word this cycle
- data_out  output  LANES  serial bit per lane, registered
- tx_active  output  1  high while data_out carries data-word bits, not idle bits

## Operation
- Derived values:
  - B = DATA_W/8, the number of bytes per word.
  - K = B/LANES, the number of bytes per lane per word.
  - The word period is 8K cycles.
- Counters:
  - bit_cnt runs 0..7.
  - slot_cnt runs 0..K-1 and has width max(1, clog2(K)).
  - Both wrap together. The word boundary (wb) is the cycle with bit_cnt==7 and slot_cnt==K-1.
- Registers:
  - cur_word is DATA_W bits; cur_is_data is 1 bit.
  - The hold register is hold_word plus hold_valid (1-entry buffer).
- Striping: byte j goes to lane j mod LANES, slot j div LANES. Slot 0 is sent first; within a byte, bit 7 is sent first.
- Every cycle:
  - data_out[l] <= bit (7-bit_cnt) of byte (slot_cnt·LANES + l) of cur_word.
  - tx_active <= cur_is_data.
- Handshake:
  - ready_out = !hold_valid && reset; it is combinational.
  - A word is accepted when valid_in && ready_out.
- Outside wb: an accepted word goes to the hold register and hold_valid is set.
- At wb, the next word is chosen in priority order:
  1. If hold_valid: load cur_word from hold_word, set cur_is_data, and clear hold_valid.
  2. Else if a word is accepted: bypass it straight into cur_word and set cur_is_data. The hold register stays empty.
  3. Else: load cur_word with all bytes = IDLE_BYTE and clear cur_is_data.
- Words are transmitted in acceptance order. None are dropped or duplicated.

## Timing
- Reset values (while reset low):
  - data_out = 0, tx_active = 0, ready_out = 0.
  - bit_cnt = 0, slot_cnt = 0, hold_valid = 0, cur_is_data = 0.
  - cur_word = all IDLE_BYTE.
- After release, edges 0..8K-1 drive the idle word. Edge 8K-1 is the first wb.
- Latency:
  - Minimum: a word accepted at the wb edge has its first bit on data_out 1 edge later.
  - Maximum: a word accepted into an empty hold reaches data_out at the edge after the next wb, at most 8K edges later.
- Throughput:
  - Back-to-back words produce a continuous bit stream with no idle gap between words.
  - ready_out drops for at most one word period while the hold register is full.
- Simultaneous events: with hold_valid=1 at wb, ready_out=0, so no acceptance is possible that cycle. The hold register frees on that edge.
- Reset mid-word: the transfer is aborted immediately.
  - The pending hold word is discarded.
  - The partially sent word is not resent.
  - Output restarts with a full idle word after release.
- K=1: every byte-end is a wb.

## Structure
- Package phy_tx_pkg holds:
  - the COM_SYM = 8'hBC constant;
  - the byte-lane/slot index functions;
  - parameter legality checks.
- One natural sub-module, phy_tx_hold: the 1-entry hold register with its ready logic.
- Counters, striping mux and output registers live in the top module.

## Test plan
- Reset release with no traffic, DATA_W=32, LANES=2:
  - Each lane repeats 1011_1100 for 16 edges, then continues repeating it.
  - tx_active stays 0 and ready_out=1.
- Single word 32'hA1B2C3D4 presented at first wb (edge 15), DATA_W=32, LANES=2:
  - Edges 16..31: lane0 sends D4 then B2, lane1 sends C3 then A1, each MSB-first.
  - tx_active=1 for exactly those 16 edges, then idle BC resumes.
- valid_in held high with incrementing words:
  - Continuous data with no idle bytes between words.
  - ready_out low for one period after each hold fill.
  - Output order equals input order.
- Word presented mid-period (edge 20, hold empty):
  - The word is held, ready_out=0 until edge 31.
  - It is transmitted starting edge 32.
  - A second valid_in at edge 22 is not accepted.
- LANES=4, DATA_W=32 (K=1), word 32'h11223344:
  - One 8-edge period puts 44/33/22/11 on lanes 0..3.
- Reset asserted at edge 24 mid-word with the hold register full:
  - data_out=0, tx_active=0, ready_out=0 immediately.
  - After release, a full idle word is sent; the held word never appears.
